// File: rtl/lua_cpu_pkg.sv
// lua_cpu_pkg: shared types and constants for the Lua execution unit.
package lua_cpu_pkg;
    typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} arb_state_e;
    localparam int AV_DW = 32;
    localparam int AV_AW = 32;
    localparam int REQ_FETCH = 0;
    localparam int REQ_RA = 1;
    localparam int REQ_WB = 2;
endpackage

// File: rtl/lua_rr_pick.sv
// lua_rr_pick: combinational round-robin selector, first candidate after last.
module lua_rr_pick #(
    parameter int N = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  cand,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);
    // Walk from farthest to nearest so the nearest candidate is written last.
    always_comb begin
        found = 1'b0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (cand[(int'(last) + k) % N]) begin
                found = 1'b1;
                idx = IW'((int'(last) + k) % N);
            end
        end
    end
endmodule

// File: rtl/lua_mem_arbiter.sv
// lua_mem_arbiter: round-robin arbiter with lock sharing one Avalon-MM master.
module lua_mem_arbiter
    import lua_cpu_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int MAX_LOCK = 16
) (
    input  logic                 clock_sink_clk,
    input  logic                 reset_sink_reset_n,
    input  logic [NREQ-1:0]      req_read,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AV_AW-1:0] req_address,
    input  logic [NREQ*AV_DW-1:0] req_writedata,
    output logic [NREQ-1:0]      req_waitrequest,
    output logic [AV_DW-1:0]     req_readdata,
    output logic [NREQ-1:0]      grant,
    output logic [AV_AW-1:0]     avalon_master_address,
    output logic [AV_DW-1:0]     avalon_master_writedata,
    output logic                 avalon_master_read,
    output logic                 avalon_master_write,
    input  logic [AV_DW-1:0]     avalon_master_readdata,
    input  logic                 avalon_master_waitrequest,
    output logic                 protocol_err,
    output logic                 lock_timeout
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e    state_q, state_d;
    logic [IW-1:0] g_q, g_d, last_q, last_d, win;
    logic [7:0]    lcnt_q, lcnt_d;
    logic          perr_q, perr_d, lto_q, lto_d, found, cmd;

    lua_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .cand  (req_read | req_write),
        .last  (last_q),
        .found (found),
        .idx   (win)
    );

    assign req_readdata = avalon_master_readdata;
    assign protocol_err = perr_q;
    assign lock_timeout = lto_q;
    assign cmd = req_read[g_q] | req_write[g_q];

    always_comb begin
        grant = '0;
        avalon_master_address = '0;
        avalon_master_writedata = '0;
        avalon_master_read = 1'b0;
        avalon_master_write = 1'b0;
        req_waitrequest = '1;
        if (state_q == GRANTED) begin
            grant[g_q] = 1'b1;
            avalon_master_address = req_address[AV_AW*int'(g_q) +: AV_AW];
            avalon_master_writedata = req_writedata[AV_DW*int'(g_q) +: AV_DW];
            avalon_master_read = req_read[g_q] & ~req_write[g_q];
            avalon_master_write = req_write[g_q];
            req_waitrequest[g_q] = avalon_master_waitrequest;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d = g_q;
        last_d = last_q;
        lcnt_d = lcnt_q;
        lto_d = lto_q;
        perr_d = perr_q | |(req_read & req_write);
        if (state_q == IDLE) begin
            if (found) begin
                state_d = GRANTED;
                g_d = win;
                last_d = win;
                lcnt_d = '0;
            end
        end else if (cmd) begin
            // A stalled command holds the bus and freezes the lock counter.
            if (!avalon_master_waitrequest) begin
                state_d = req_lock[g_q] ? GRANTED : IDLE;
                lcnt_d = '0;
            end
        end else if (!req_lock[g_q]) begin
            state_d = IDLE;
        end else begin
            lcnt_d = lcnt_q + 8'd1;
            if (lcnt_q == 8'(MAX_LOCK - 1)) begin
                lto_d = 1'b1;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clock_sink_clk) begin
        if (!reset_sink_reset_n) begin
            state_q <= IDLE;
            g_q <= '0;
            last_q <= IW'(NREQ - 1);
            lcnt_q <= '0;
            perr_q <= 1'b0;
            lto_q <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q <= g_d;
            last_q <= last_d;
            lcnt_q <= lcnt_d;
            perr_q <= perr_d;
            lto_q <= lto_d;
        end
    end
endmodule
